// File: rtl/dcache_4kb.sv
// 4 KB single-ported tagged data memory with a fixed-latency response pipeline.
// Every request (read or write) returns its tag LATENCY cycles after acceptance; no backpressure.
module dcache_4kb #(
  parameter int ID_W    = 4,
  parameter int LATENCY = 2,
  parameter int WORDS   = 1024
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            memR,
  input  logic            memW,
  input  logic [ID_W-1:0] ldstID,
  input  logic [31:0]     addr,
  input  logic [31:0]     Wdata,
  output logic [31:0]     Rdata,
  output logic [ID_W-1:0] ldstID_out,
  output logic            ready_out
);

  localparam int AW = $clog2(WORDS);

  logic [31:0]     mem [WORDS] = '{default: '0};
  logic [AW-1:0]   idx;
  logic            req;
  logic [31:0]     req_dat;

  logic [LATENCY-1:0] vld;
  logic [ID_W-1:0]    sid  [LATENCY];
  logic [31:0]        sdat [LATENCY];

  assign idx     = addr[AW+1:2];
  assign req     = memR | memW;
  // Writes win over reads and echo their own data; reads see all earlier edges' writes.
  assign req_dat = memW ? Wdata : mem[idx];

  always_ff @(posedge clk) begin
    if (!rst && memW) begin
      mem[idx] <= Wdata;
    end
  end

  // Each slot only loads when a valid entry arrives, so the output stage holds its last response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
      for (int k = 0; k < LATENCY; k++) begin
        sid[k]  <= '0;
        sdat[k] <= '0;
      end
    end else begin
      vld[0] <= req;
      if (req) begin
        sid[0]  <= ldstID;
        sdat[0] <= req_dat;
      end
      for (int k = 1; k < LATENCY; k++) begin
        vld[k] <= vld[k-1];
        if (vld[k-1]) begin
          sid[k]  <= sid[k-1];
          sdat[k] <= sdat[k-1];
        end
      end
    end
  end

  assign ready_out  = vld[LATENCY-1];
  assign ldstID_out = sid[LATENCY-1];
  assign Rdata      = sdat[LATENCY-1];

endmodule

// File: tb/tb_dcache_4kb.sv
// Scoreboard bench for dcache_4kb: stimulus pushes expected responses, a negedge monitor pops and checks.
module tb_dcache_4kb;
  localparam int ID_W = 4;
  localparam int LAT  = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            memR, memW;
  logic [ID_W-1:0] ldstID;
  logic [31:0]     addr, Wdata;
  logic [31:0]     Rdata;
  logic [ID_W-1:0] ldstID_out;
  logic            ready_out;

  typedef struct {
    logic [ID_W-1:0] id;
    logic [31:0]     dat;
    int              cyc;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  dcache_4kb #(.ID_W(ID_W), .LATENCY(LAT), .WORDS(1024)) dut (
    .clk(clk), .rst(rst), .memR(memR), .memW(memW), .ldstID(ldstID),
    .addr(addr), .Wdata(Wdata), .Rdata(Rdata), .ldstID_out(ldstID_out),
    .ready_out(ready_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: compare each response pulse against the head of the scoreboard.
  always @(negedge clk) begin
    if (ready_out) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready: got tag %0d data 0x%0h with nothing outstanding", ldstID_out, Rdata);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("resp_tag", 32'(ldstID_out), 32'(e.id));
        chk("resp_data", Rdata, e.dat);
        chk("resp_cycle", 32'(cyc), 32'(e.cyc));
      end
    end else if (q.size() != 0 && q[0].cyc <= cyc) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_ready: tag %0d due at cycle %0d, no pulse by cycle %0d", e.id, e.cyc, cyc);
    end
  end

  task automatic issue(input logic r, input logic w, input logic [ID_W-1:0] id,
                       input logic [31:0] a, input logic [31:0] d, input logic [31:0] expd);
    exp_t e;
    memR = r; memW = w; ldstID = id; addr = a; Wdata = d;
    e.id = id; e.dat = expd; e.cyc = cyc + LAT;
    q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    memR = 1'b0; memW = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    rst = 1'b1; memR = 1'b0; memW = 1'b0; ldstID = '0; addr = '0; Wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready", 32'(ready_out), 32'd0);
    chk("reset_tag", 32'(ldstID_out), 32'd0);
    chk("reset_data", Rdata, 32'd0);
    rst = 1'b0;
    idle(1);

    // Back-to-back writes then reads.
    issue(1'b0, 1'b1, 4'd1, 32'd40, 32'd9000, 32'd9000);
    issue(1'b0, 1'b1, 4'd2, 32'd44, 32'd9001, 32'd9001);
    issue(1'b1, 1'b0, 4'd3, 32'd40, 32'd0,    32'd9000);
    issue(1'b1, 1'b0, 4'd4, 32'd44, 32'd0,    32'd9001);
    idle(4);

    // Unwritten location reads zero.
    issue(1'b1, 1'b0, 4'd7, 32'h80, 32'hffff_ffff, 32'd0);
    idle(3);

    // Read and write together behave as a write with a single ack.
    issue(1'b1, 1'b1, 4'd5, 32'd8, 32'h55, 32'h55);
    issue(1'b1, 1'b0, 4'd6, 32'd8, 32'd0,  32'h55);
    idle(3);

    // Address alias and ignored low bits; duplicate tags pass through unchanged.
    issue(1'b0, 1'b1, 4'd8, 32'h004,  32'd7, 32'd7);
    issue(1'b1, 1'b0, 4'd9, 32'h1006, 32'd0, 32'd7);
    issue(1'b0, 1'b1, 4'd3, 32'h100,  32'hdead_beef, 32'hdead_beef);
    issue(1'b1, 1'b0, 4'd3, 32'h100,  32'd0, 32'hdead_beef);
    idle(4);

    // Reset with reads in flight drops their responses.
    issue(1'b1, 1'b0, 4'd10, 32'd40, 32'd0, 32'd9000);
    issue(1'b1, 1'b0, 4'd11, 32'd44, 32'd0, 32'd9001);
    memR = 1'b0; memW = 1'b0;
    rst = 1'b1;
    q.delete();
    #1;
    chk("midrst_ready", 32'(ready_out), 32'd0);
    chk("midrst_tag", 32'(ldstID_out), 32'd0);
    chk("midrst_data", Rdata, 32'd0);
    repeat (2) begin
      @(posedge clk); #1;
      chk("rst_hold_ready", 32'(ready_out), 32'd0);
    end
    rst = 1'b0;
    idle(4);
    issue(1'b1, 1'b0, 4'd12, 32'd44, 32'd0, 32'd9001);
    idle(4);

    // Idle: no pulses.
    for (int i = 0; i < 5; i++) begin
      chk("idle_ready", 32'(ready_out), 32'd0);
      idle(1);
    end

    for (int i = 0; i < 20 && q.size() != 0; i++) idle(1);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d responses still outstanding, expected 0", q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
